// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner: geometry, key codes, press FSM states.
// Pure declarations; no timing or flow control of its own.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = $clog2(NUM_COLS);

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CAND,
        PRESSED,
        REL_CAND
    } press_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_class_t;

    // One row vector per column, captured at the end of that column's window.
    typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] frame_t;

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
        return ~(NUM_COLS'(1) << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: column drive out, row sense in, accepted-key report out.
// The scanner owns the slave modport; the keypad/consumer side uses master.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic                enable;
    logic [NUM_ROWS-1:0] rows;
    logic [NUM_COLS-1:0] cols;
    key_code_t           key_code;
    logic                key_valid;
    logic                key_held;

    modport master (
        output enable,
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  enable,
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

endinterface

// File: rtl/keypad_scanner_input_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs; 2 cycles latency, no backpressure.
// Synchronous active-low reset loads RESET_VAL into both stages.
module input_synchronizer #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, frame capture/classify, frame-debounced press FSM.
// Accept pulse lands 1 cycle after the frame is evaluated; no backpressure, one pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    keypad_scanner_if.slave kp
);

    localparam int CW = $clog2(SCAN_CYCLES);
    localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]    SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [FW-1:0]    DEB_TGT   = FW'(DEBOUNCE_FRAMES);
    localparam logic [FW-1:0]    CNT_ONE   = FW'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(NUM_COLS - 1);

    logic [NUM_ROWS-1:0] rows_sync;

    input_synchronizer #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_rows_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (kp.rows),
        .q_o     (rows_sync)
    );

    // ---------------- column scan and frame capture ----------------
    logic             run_q, run_d;
    logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [COL_W-1:0] col_idx_q, col_idx_d;
    frame_t           frame_q, frame_d;
    logic             frame_vld_q, frame_vld_d;
    logic             col_last;

    assign col_last = run_q && (scan_cnt_q == SCAN_LAST);

    always_comb begin
        run_d       = kp.enable;
        scan_cnt_d  = scan_cnt_q;
        col_idx_d   = col_idx_q;
        frame_d     = frame_q;
        frame_vld_d = 1'b0;
        if (!kp.enable) begin
            scan_cnt_d = '0;
            col_idx_d  = '0;
            frame_d    = '1;
        end else if (col_last) begin
            scan_cnt_d         = '0;
            col_idx_d          = col_idx_q + 1'b1;
            frame_d[col_idx_q] = rows_sync;
            frame_vld_d        = (col_idx_q == COL_LAST);
        end else if (run_q) begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            scan_cnt_q  <= '0;
            col_idx_q   <= '0;
            frame_q     <= '1;
            frame_vld_q <= 1'b0;
        end else begin
            run_q       <= run_d;
            scan_cnt_q  <= scan_cnt_d;
            col_idx_q   <= col_idx_d;
            frame_q     <= frame_d;
            frame_vld_q <= frame_vld_d;
        end
    end

    // Columns are released whenever the scanner is not running, including the reset cycle.
    assign kp.cols = run_q ? col_drive(col_idx_q) : '1;

    // ---------------- frame classifier ----------------
    frame_class_t fr_class;
    key_code_t    fr_code;

    always_comb begin
        fr_class = FR_NONE;
        fr_code  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (!frame_q[c][r]) begin
                    if (fr_class == FR_NONE) begin
                        fr_class = FR_SINGLE;
                        fr_code  = key_code_t'(r * NUM_COLS + c);
                    end else begin
                        fr_class = FR_MULTI;
                    end
                end
            end
        end
    end

    // ---------------- press FSM ----------------
    press_state_t state_q, state_d;
    key_code_t    cand_q, cand_d;
    key_code_t    key_code_q, key_code_d;
    logic [FW-1:0] cnt_q, cnt_d, cnt_inc;
    logic         key_valid_q, key_valid_d;
    logic         key_held_q, key_held_d;
    logic         is_cand, is_key;

    assign cnt_inc = (cnt_q == DEB_TGT) ? cnt_q : cnt_q + 1'b1;
    assign is_cand = (fr_class == FR_SINGLE) && (fr_code == cand_q);
    assign is_key  = (fr_class == FR_SINGLE) && (fr_code == key_code_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RELEASED;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else if (!kp.enable) begin
            state_q     <= RELEASED;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frame_vld_q) begin
            unique case (state_q)
                RELEASED: begin
                    if (fr_class == FR_SINGLE) begin
                        cand_d  = fr_code;
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE_FRAMES <= 1) ? PRESSED : PRESS_CAND;
                    end
                end
                PRESS_CAND: begin
                    if (is_cand) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_TGT) state_d = PRESSED;
                    end else if (fr_class == FR_SINGLE) begin
                        cand_d = fr_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = RELEASED;
                    end
                end
                PRESSED: begin
                    if (!is_key) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE_FRAMES <= 1) ? RELEASED : REL_CAND;
                    end
                end
                REL_CAND: begin
                    // Only the held key can cancel a release; other keys count as release frames.
                    if (is_key) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_TGT) state_d = RELEASED;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    always_comb begin
        key_valid_d = frame_vld_q && (state_d == PRESSED) &&
                      ((state_q == RELEASED) || (state_q == PRESS_CAND));
        key_code_d  = key_valid_d ? cand_d : key_code_q;
        key_held_d  = (state_d == PRESSED) || (state_d == REL_CAND);
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.key_valid = key_valid_q && kp.enable && reset_n;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a keypad matrix model and an expected-code scoreboard.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int FRAME   = 32;
    localparam int ACC_LAT = 3 * FRAME + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_CYCLES     (8),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kif)
    );

    logic [15:0] keys = '0;
    logic [3:0]  rows_m;

    always_comb begin
        rows_m = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kif.cols[c] && keys[r*4+c]) rows_m[r] = 1'b0;
    end
    assign kif.rows = rows_m;

    int vectors   = 0;
    int errors    = 0;
    int cyc       = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    logic prev_valid = 1'b0;
    key_code_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n || !kif.enable) chk("valid_idle", 32'(kif.key_valid), 0);
        if (kif.key_valid) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            chk("no_double", 32'(prev_valid), 0);
            if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
            else                   chk("key_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
        end
        prev_valid = kif.key_valid;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic frame_start(output int t0);
        int b;
        b = 0;
        while (kif.cols !== 4'b0111 && b < 200) begin step(); b++; end
        while (kif.cols !== 4'b1110 && b < 240) begin step(); b++; end
        if (b >= 240) chk("frame_sync_timeout", 0, 1);
        t0 = cyc;
    endtask

    task automatic wait_pulse(input string tag, input int t0, input int p0, input int lat);
        int b;
        b = 0;
        while (pulse_cnt == p0 && b < lat + 64) begin step(); b++; end
        if (pulse_cnt == p0) chk({tag, "_timeout"}, 0, 1);
        else                 chk({tag, "_latency"}, 32'(pulse_cyc - t0), 32'(lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int p0;
        kif.enable = 1'b1;
        reset_n    = 1'b0;

        // reset state and column scan order
        step(3);
        chk("rst_cols", 32'(kif.cols), 32'hF);
        chk("rst_code", 32'(kif.key_code), 0);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_held", 32'(kif.key_held), 0);
        reset_n = 1'b1;
        step();
        chk("first_col", 32'(kif.cols), 32'hE);
        step(7);
        chk("col0_hold", 32'(kif.cols), 32'hE);
        step();
        chk("col1", 32'(kif.cols), 32'hD);

        // steady press of r2,c1
        frame_start(t0);
        p0   = pulse_cnt;
        keys = 16'(1 << 9);
        exp_q.push_back(4'd9);
        wait_pulse("t2_accept", t0, p0, ACC_LAT);
        chk("t2_held", 32'(kif.key_held), 1);
        p0 = pulse_cnt;
        step(20 * FRAME);
        chk("t2_no_repeat", 32'(pulse_cnt), 32'(p0));
        chk("t2_held_long", 32'(kif.key_held), 1);

        // release debounce, then press r3,c3
        frame_start(t0);
        keys = '0;
        step(ACC_LAT - 1);
        chk("t5_held_before", 32'(kif.key_held), 1);
        step();
        chk("t5_held_fall", 32'(kif.key_held), 0);
        frame_start(t0);
        p0   = pulse_cnt;
        keys = 16'(1 << 15);
        exp_q.push_back(4'd15);
        wait_pulse("t5_accept", t0, p0, ACC_LAT);

        // enable drop mid-frame while held
        step(10);
        p0         = pulse_cnt;
        kif.enable = 1'b0;
        step();
        chk("t6_en_cols", 32'(kif.cols), 32'hF);
        chk("t6_en_held", 32'(kif.key_held), 0);
        chk("t6_en_code", 32'(kif.key_code), 15);
        step(5);
        chk("t6_en_no_pulse", 32'(pulse_cnt), 32'(p0));
        kif.enable = 1'b1;
        step();
        t0 = cyc;
        chk("t6_en_restart_col", 32'(kif.cols), 32'hE);
        exp_q.push_back(4'd15);
        wait_pulse("t6_en_accept", t0, p0, ACC_LAT);

        // reset mid-frame while held
        step(13);
        p0      = pulse_cnt;
        reset_n = 1'b0;
        step();
        chk("t6_rst_cols", 32'(kif.cols), 32'hF);
        chk("t6_rst_held", 32'(kif.key_held), 0);
        chk("t6_rst_code", 32'(kif.key_code), 0);
        step(2);
        reset_n = 1'b1;
        step();
        t0 = cyc;
        chk("t6_rst_restart_col", 32'(kif.cols), 32'hE);
        exp_q.push_back(4'd15);
        wait_pulse("t6_rst_accept", t0, p0, ACC_LAT);
        frame_start(t0);
        keys = '0;
        step(4 * FRAME);
        chk("t6_released", 32'(kif.key_held), 0);

        // key present on alternate frames only
        p0 = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            frame_start(t0);
            keys = (i % 2 == 0) ? 16'(1 << 9) : 16'h0;
        end
        frame_start(t0);
        keys = '0;
        step(2 * FRAME);
        chk("t3_no_pulse", 32'(pulse_cnt), 32'(p0));
        chk("t3_held", 32'(kif.key_held), 0);

        // two keys together are ghosted, then the remaining one is accepted
        frame_start(t0);
        keys = 16'((1 << 0) | (1 << 6));
        step(10 * FRAME);
        chk("t4_ghost_no_pulse", 32'(pulse_cnt), 32'(p0));
        chk("t4_ghost_held", 32'(kif.key_held), 0);
        frame_start(t0);
        p0   = pulse_cnt;
        keys = 16'(1 << 0);
        exp_q.push_back(4'd0);
        wait_pulse("t4_accept", t0, p0, ACC_LAT);
        chk("t4_held", 32'(kif.key_held), 1);

        step(4);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
